// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix driver with a double-buffered ROWS x COLS frame.
// Scans one row at a time with dead-time blanking between rows. Host writes
// go to the back buffer, and a requested swap takes effect only at a frame
// boundary, so a frame never tears.
module led_matrix_scanner #(
    parameter int unsigned ROWS           = 8,
    parameter int unsigned COLS           = 8,
    parameter int unsigned SCAN_DIV       = 2000,
    parameter int unsigned BLANK_CYC      = 16,
    parameter bit          ROW_ACTIVE_LOW = 1'b0,
    parameter bit          COL_ACTIVE_LOW = 1'b0,
    localparam int unsigned ROW_W         = $clog2(ROWS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COLS-1:0]  wr_data,
    input  logic             swap_req,
    output logic             swap_pending,
    output logic             swap_done,
    output logic             frame_start,
    output logic [ROWS-1:0]  row_out,
    output logic [COLS-1:0]  col_out
);

    localparam int unsigned CNT_MAX  = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam bit          ROW_POW2 = (ROWS == (1 << ROW_W));
    localparam logic [ROWS-1:0] ROW_POL = {ROWS{ROW_ACTIVE_LOW}};
    localparam logic [COLS-1:0] COL_POL = {COLS{COL_ACTIVE_LOW}};

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [ROW_W-1:0] row_idx;
    logic [ROW_W-1:0] row_idx_nxt;
    logic             frame_end;

    // bank selects the back buffer; the other half is the visible front
    logic             bank;
    logic [COLS-1:0]  mem [2][ROWS];

    logic             wr_ok;
    logic             swap_exec;
    logic [ROWS-1:0]  row_out_nxt;
    logic [COLS-1:0]  col_out_nxt;
    logic             frame_start_nxt;

    // Out-of-range row indices can only occur when ROWS is not a power of two
    assign wr_ok     = ROW_POW2 || (wr_row < ROW_W'(ROWS));
    assign swap_exec = frame_end && swap_pending;

    // Scan state register: phase, in-phase counter and current row
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_BLANK;
            cnt     <= '0;
            row_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            row_idx <= row_idx_nxt;
        end
    end

    // Next-state: BLANK for BLANK_CYC cycles, DRIVE for SCAN_DIV, advance row on DRIVE exit
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        row_idx_nxt = row_idx;
        frame_end   = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == CNT_W'(BLANK_CYC - 1)) begin
                    state_nxt = ST_DRIVE;
                    cnt_nxt   = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt == CNT_W'(SCAN_DIV - 1)) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                    if (row_idx == ROW_W'(ROWS - 1)) begin
                        row_idx_nxt = '0;
                        frame_end   = 1'b1;
                    end else begin
                        row_idx_nxt = row_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output next values: pads follow the upcoming phase, columns latched on DRIVE entry
    always_comb begin
        row_out_nxt     = ROW_POL;
        col_out_nxt     = COL_POL;
        frame_start_nxt = 1'b0;
        if (state_nxt == ST_DRIVE) begin
            row_out_nxt = (ROWS'(1) << row_idx_nxt) ^ ROW_POL;
            if (state == ST_BLANK) begin
                col_out_nxt     = mem[~bank][row_idx_nxt] ^ COL_POL;
                frame_start_nxt = (row_idx_nxt == '0);
            end else begin
                col_out_nxt = col_out;
            end
        end
    end

    // Frame buffers, bank select and swap handshake
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    mem[b][r] <= '0;
                end
            end
            bank         <= 1'b0;
            swap_pending <= 1'b0;
            swap_done    <= 1'b0;
        end else begin
            // A write on the swap edge still uses the old bank, i.e. lands in the new front
            if (wr_en && wr_ok) begin
                mem[bank][wr_row] <= wr_data;
            end
            if (swap_exec) begin
                bank         <= ~bank;
                swap_done    <= 1'b1;
                swap_pending <= swap_req;
            end else begin
                swap_done <= 1'b0;
                if (swap_req) begin
                    swap_pending <= 1'b1;
                end
            end
        end
    end

    // Registered pad outputs with polarity already applied
    always_ff @(posedge CLK) begin
        if (RST) begin
            row_out     <= ROW_POL;
            col_out     <= COL_POL;
            frame_start <= 1'b0;
        end else begin
            row_out     <= row_out_nxt;
            col_out     <= col_out_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule
